// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Parametrised synchronous up/down counter with a programmable terminal value (limit),
//   wrap or saturate behaviour at the boundaries, synchronous load/clear, a combinational
//   terminal-count flag, a registered wrap pulse and sticky overflow/underflow flags.
//
// Parameters
//   WIDTH    counter width in bits (>= 1)
//   RST_VAL  count value after reset (must fit in WIDTH bits)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable, one step per clock
//   up        in   direction, 1 = up, 0 = down
//   clr       in   synchronous clear of count and sticky flags (highest priority)
//   load      in   synchronous load of load_val, clamped to limit
//   load_val  in   value to load
//   limit     in   terminal value, counting range is 0..limit
//   sat_mode  in   0 = wrap at boundary, 1 = saturate at boundary
//   count     out  registered counter value
//   tc        out  combinational terminal count for the current direction
//   wrap_p    out  one-cycle pulse, a wrap happened on the previous edge
//   ovf       out  sticky, an up-step hit the limit boundary
//   udf       out  sticky, a down-step hit the zero boundary
module updown_counter_param #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_p,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] RstCount = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_p_q, wrap_p_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic at_top;
  logic at_zero;

  // count can sit above limit after limit is lowered; treat that as "at top" when counting up.
  assign at_top  = (count_q >= limit);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d  = count_q;
    wrap_p_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          ovf_d = 1'b1;
          if (sat_mode) begin
            count_d = limit;
          end else begin
            count_d  = '0;
            wrap_p_d = 1'b1;
          end
        end else begin
          count_d = count_q + One;
        end
      end else begin
        if (at_zero) begin
          udf_d = 1'b1;
          if (!sat_mode) begin
            count_d  = limit;
            wrap_p_d = 1'b1;
          end
        end else begin
          // Above-limit values simply step down toward the range without flagging.
          count_d = count_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= RstCount;
      wrap_p_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_p_q <= wrap_p_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign count  = count_q;
  assign wrap_p = wrap_p_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;
  assign tc     = en & ((up & at_top) | (~up & at_zero));

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

  typedef struct {
    int c;
    bit wp;
    bit ov;
    bit ud;
  } st_t;

  logic       clk = 1'b0;
  logic       rst_n, en, up, clr, load, sat;
  logic [3:0] lv4, lim4, cnt4;
  logic [7:0] lv8, lim8, cnt8;
  logic       tc4, wp4, ov4, ud4;
  logic       tc8, wp8, ov8, ud8;

  int  checks = 0;
  int  errors = 0;
  bit  cmp_on = 1'b0;
  st_t m4, m8;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4), .RST_VAL(0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv4), .limit(lim4), .sat_mode(sat),
    .count(cnt4), .tc(tc4), .wrap_p(wp4), .ovf(ov4), .udf(ud4)
  );

  updown_counter_param #(.WIDTH(8), .RST_VAL(5)) u_d8 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv8), .limit(lim8), .sat_mode(sat),
    .count(cnt8), .tc(tc8), .wrap_p(wp8), .ovf(ov8), .udf(ud8)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  function automatic st_t step(input st_t s, input int lim, input int lv);
    st_t n = s;
    n.wp = 1'b0;
    if (clr) begin
      n.c = 0; n.ov = 1'b0; n.ud = 1'b0;
    end else if (load) begin
      n.c = (lv > lim) ? lim : lv;
    end else if (en) begin
      if (up) begin
        if (s.c < lim) n.c = s.c + 1;
        else begin
          n.ov = 1'b1;
          if (sat) n.c = lim;
          else begin n.c = 0; n.wp = 1'b1; end
        end
      end else begin
        if (s.c > 0) n.c = s.c - 1;
        else begin
          n.ud = 1'b1;
          if (!sat) begin n.c = lim; n.wp = 1'b1; end
        end
      end
    end
    return n;
  endfunction

  function automatic int tc_of(input int c, input int lim);
    return int'(en && ((up && c >= lim) || (!up && c == 0)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= '{c: 0, wp: 1'b0, ov: 1'b0, ud: 1'b0};
      m8 <= '{c: 5, wp: 1'b0, ov: 1'b0, ud: 1'b0};
    end else begin
      m4 <= step(m4, int'(lim4), int'(lv4));
      m8 <= step(m8, int'(lim8), int'(lv8));
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cmp count4", int'(cnt4), m4.c);
      check("cmp wrap4", int'(wp4), int'(m4.wp));
      check("cmp ovf4", int'(ov4), int'(m4.ov));
      check("cmp udf4", int'(ud4), int'(m4.ud));
      check("cmp tc4", int'(tc4), tc_of(m4.c, int'(lim4)));
      check("cmp count8", int'(cnt8), m8.c);
      check("cmp wrap8", int'(wp8), int'(m8.wp));
      check("cmp ovf8", int'(ov8), int'(m8.ov));
      check("cmp udf8", int'(ud8), int'(m8.ud));
      check("cmp tc8", int'(tc8), tc_of(m8.c, int'(lim8)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; clr = 1'b0; load = 1'b0;
  endtask

  initial begin
    int tc_hits;
    rst_n = 1'b0; idle(); up = 1'b1; sat = 1'b0;
    lv4 = '0; lim4 = 4'd15; lv8 = '0; lim8 = 8'd255;
    tick();
    check("reset count4", int'(cnt4), 0);
    check("reset count8 RST_VAL", int'(cnt8), 5);
    check("reset flags4", int'({wp4, ov4, ud4}), 0);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    // Up/wrap with limit 9 for 12 clocks from 0.
    clr = 1'b1; tick(); clr = 1'b0;
    lim4 = 4'd9; up = 1'b1; sat = 1'b0; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("wrap9 count", int'(cnt4), (i + 1) % 10);
      check("wrap9 pulse", int'(wp4), int'(i == 9));
    end
    check("wrap9 ovf", int'(ov4), 1);

    // Down/saturate from 2.
    idle(); clr = 1'b1; tick(); clr = 1'b0;
    load = 1'b1; lv4 = 4'd2; tick(); load = 1'b0;
    up = 1'b0; sat = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat down count", int'(cnt4), (i == 0) ? 1 : 0);
      check("sat down pulse", int'(wp4), 0);
    end
    check("sat down udf", int'(ud4), 1);

    // Load clamps to limit; clr beats load.
    idle(); load = 1'b1; lv4 = 4'd12; lim4 = 4'd9; tick();
    check("load clamp", int'(cnt4), 9);
    clr = 1'b1; tick(); idle();
    check("clr over load", int'(cnt4), 0);
    check("clr flags", int'({ov4, ud4}), 0);

    // count above a lowered limit.
    lim4 = 4'd15; load = 1'b1; lv4 = 4'd12; tick(); load = 1'b0;
    check("load 12", int'(cnt4), 12);
    lim4 = 4'd5; up = 1'b1; sat = 1'b0; en = 1'b1; tick(); en = 1'b0;
    check("above lim up wraps", int'(cnt4), 0);
    check("above lim ovf", int'(ov4), 1);
    lim4 = 4'd15; load = 1'b1; tick(); load = 1'b0;
    lim4 = 4'd5; up = 1'b0; en = 1'b1; tick(); en = 1'b0;
    check("above lim down", int'(cnt4), 11);
    check("above lim no udf", int'(ud4), 0);
    check("above lim no pulse", int'(wp4), 0);

    // Asynchronous reset mid-count.
    lim4 = 4'd15; load = 1'b1; lv4 = 4'd7; tick(); load = 1'b0;
    up = 1'b1; en = 1'b1;
    check("pre reset", int'(cnt4), 7);
    rst_n = 1'b0; #1;
    check("async reset count", int'(cnt4), 0);
    check("async reset flags", int'({wp4, ov4, ud4}), 0);
    #1 rst_n = 1'b1;
    idle();

    // 8-bit full-range counter wraps after 256 steps, tc only at 255.
    clr = 1'b1; tick(); clr = 1'b0;
    lim8 = 8'd255; up = 1'b1; sat = 1'b0; en = 1'b1;
    tc_hits = 0;
    for (int i = 0; i < 256; i++) begin
      check("bin8 count", int'(cnt8), i);
      if (tc8) tc_hits++;
      tick();
    end
    check("bin8 return to 0", int'(cnt8), 0);
    check("bin8 tc hits", tc_hits, 1);
    idle();

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      up   = $urandom_range(0, 1) == 1;
      sat  = $urandom_range(0, 1) == 1;
      clr  = ($urandom_range(0, 49) == 0);
      load = ($urandom_range(0, 9) == 0);
      lv4  = 4'($urandom);
      lv8  = 8'($urandom);
      case ($urandom_range(0, 9))
        0: begin lim4 = '0; lim8 = '0; end
        1: begin lim4 = '1; lim8 = '1; end
        2, 3: begin lim4 = 4'($urandom); lim8 = 8'($urandom); end
        default: ;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0; #2; rst_n = 1'b1;
      end
      tick();
    end

    idle(); tick();
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
